cpu_bus_stim: RTL and testbench

Parametrised, synthesizable bus responder and interrupt scheduler for CPU bring-up.
- Serves CPU reads combinationally from a RAM that mirrors across the address space, plus a dedicated 6-byte vector region.
- Captures CPU writes and counts them.
- Drives active-low irq/nmi from a bank of programmable cycle windows.
- Sits directly on the CPU bus. It replaces hand-coded program cases and commented-out interrupt code in benches, and can also be used on the FPGA.

---
 rtl/cpu_bus_stim_pkg.sv | 46 ++++
 rtl/cpu_bus_stim_if.sv | 24 ++
 rtl/cpu_bus_stim_irq_window_sched.sv | 96 +++++++++
 rtl/cpu_bus_stim.sv | 146 ++++++++++++++
 tb/tb_cpu_bus_stim.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_stim_pkg.sv
// Shared constants for the CPU bus responder: vector region base, window config
// field codes, interrupt kinds, and 6502 opcodes for benches that build programs.
package cpu_bus_pkg;

    localparam logic [15:0] VEC_BASE  = 16'hFFFA;
    localparam int          VEC_BYTES = 6;

    typedef enum logic [1:0] {
        FLD_START = 2'd0,
        FLD_END   = 2'd1,
        FLD_CTRL  = 2'd2,
        FLD_RSVD  = 2'd3
    } cfg_fld_e;

    typedef enum logic {
        KIND_IRQ = 1'b0,
        KIND_NMI = 1'b1
    } win_kind_e;

    // Layout of cfg_data[1:0] when cfg_fld selects the ctrl field.
    typedef struct packed {
        logic kind;
        logic en;
    } win_ctrl_t;

    localparam logic [7:0] OP_BRK     = 8'h00;
    localparam logic [7:0] OP_RTI     = 8'h40;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_CLI     = 8'h58;
    localparam logic [7:0] OP_SEI     = 8'h78;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_BNE     = 8'hD0;
    localparam logic [7:0] OP_INX     = 8'hE8;
    localparam logic [7:0] OP_NOP     = 8'hEA;

    function automatic win_ctrl_t ctrl_word(input win_kind_e kind, input logic en);
        win_ctrl_t c;
        c.kind = kind;
        c.en   = en;
        return c;
    endfunction

endpackage

// File: rtl/cpu_bus_stim_if.sv
// CPU-side bus bundle. Every clk_ph1 posedge is one bus cycle; there is no
// valid/ready: R_nW = 0 at the edge is a write, and read data is always valid
// combinationally for the current Addr_bus. irq/nmi are active-low.
interface cpu_bus_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] Addr_bus;
    logic [DATA_W-1:0] Data_bus_out;
    logic              R_nW;
    logic [DATA_W-1:0] Data_bus_in;
    logic              irq;
    logic              nmi;

    modport master (
        output Addr_bus, Data_bus_out, R_nW,
        input  Data_bus_in, irq, nmi
    );

    modport slave (
        input  Addr_bus, Data_bus_out, R_nW,
        output Data_bus_in, irq, nmi
    );
endinterface

// File: rtl/cpu_bus_stim_irq_window_sched.sv
// Free-running saturating cycle counter plus a bank of programmable windows that
// drive registered active-low irq/nmi while the counter sits inside [start, end).
module irq_window_sched
    import cpu_bus_pkg::*;
#(
    parameter int NUM_WIN = 4,
    parameter int CNT_W   = 16,
    parameter int WIN_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [WIN_W-1:0] cfg_win,
    input  logic [1:0]       cfg_fld,
    input  logic [CNT_W-1:0] cfg_data,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             irq,
    output logic             nmi
);

    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nxt;
    logic [CNT_W-1:0]   start_q [NUM_WIN];
    logic [CNT_W-1:0]   start_d [NUM_WIN];
    logic [CNT_W-1:0]   end_q   [NUM_WIN];
    logic [CNT_W-1:0]   end_d   [NUM_WIN];
    logic [NUM_WIN-1:0] en_q, en_d;
    logic [NUM_WIN-1:0] kind_q, kind_d;
    logic [NUM_WIN-1:0] hit;
    logic               irq_q, irq_d;
    logic               nmi_q, nmi_d;
    win_ctrl_t          ctrl_in;

    assign ctrl_in = win_ctrl_t'(cfg_data[1:0]);

    always_comb begin
        start_d = start_q;
        end_d   = end_q;
        en_d    = en_q;
        kind_d  = kind_q;
        if (cfg_we) begin
            for (int w = 0; w < NUM_WIN; w++) begin
                if (cfg_win == WIN_W'(w)) begin
                    case (cfg_fld_e'(cfg_fld))
                        FLD_START: start_d[w] = cfg_data;
                        FLD_END:   end_d[w]   = cfg_data;
                        FLD_CTRL: begin
                            en_d[w]   = ctrl_in.en;
                            kind_d[w] = ctrl_in.kind;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Comparing against the next count makes the registered outputs line up
    // with the cycle_cnt value that becomes visible at the same edge.
    always_comb begin
        cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        cnt_d   = cnt_nxt;
        hit     = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            hit[w] = en_q[w] && (start_q[w] <= cnt_nxt) && (cnt_nxt < end_q[w]);
        end
        irq_d = ~|(hit & ~kind_q);
        nmi_d = ~|(hit & kind_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            en_q   <= '0;
            kind_q <= '0;
            irq_q  <= 1'b1;
            nmi_q  <= 1'b1;
            for (int w = 0; w < NUM_WIN; w++) begin
                start_q[w] <= '0;
                end_q[w]   <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            kind_q  <= kind_d;
            irq_q   <= irq_d;
            nmi_q   <= nmi_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    assign cycle_cnt = cnt_q;
    assign irq       = irq_q;
    assign nmi       = nmi_q;

endmodule

// File: rtl/cpu_bus_stim.sv
// CPU bus responder: mirrored RAM plus a 6-byte vector region with zero-latency
// reads, preload port, CPU write log, and the interrupt window scheduler.
module cpu_bus_stim
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int MEM_AW  = 11,
    parameter int NUM_WIN = 4,
    parameter int CNT_W   = 16,
    parameter int WIN_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic              clk_ph1,
    input  logic              rst,
    cpu_bus_if.slave          bus,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              cfg_we,
    input  logic [WIN_W-1:0]  cfg_win,
    input  logic [1:0]        cfg_fld,
    input  logic [CNT_W-1:0]  cfg_data,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [15:0]       wr_cnt,
    output logic [ADDR_W-1:0] last_wr_addr,
    output logic [DATA_W-1:0] last_wr_data,
    output logic              wr_drop
);

    localparam logic [ADDR_W-1:0] VEC_LO = ADDR_W'(VEC_BASE);

    function automatic logic in_vec(input logic [ADDR_W-1:0] a);
        return a >= VEC_LO;
    endfunction

    function automatic logic [2:0] vec_idx(input logic [ADDR_W-1:0] a);
        return 3'(a - VEC_LO);
    endfunction

    logic [DATA_W-1:0] mem_q [2**MEM_AW];
    logic [DATA_W-1:0] vec_q [VEC_BYTES];
    logic [DATA_W-1:0] vec_d [VEC_BYTES];

    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic              wr_drop_q, wr_drop_d;

    logic              mem_we;
    logic [MEM_AW-1:0] mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_data;
    logic [2:0]        rd_idx;
    logic [2:0]        ld_idx;
    logic              cpu_wr;
    logic              irq_w, nmi_w;

    // Read path depends only on address and stored state, never on R_nW.
    always_comb begin
        rd_idx  = vec_idx(bus.Addr_bus);
        rd_data = mem_q[bus.Addr_bus[MEM_AW-1:0]];
        if (in_vec(bus.Addr_bus)) begin
            rd_data = '0;
            for (int i = 0; i < VEC_BYTES; i++) begin
                if (rd_idx == 3'(i)) rd_data = vec_q[i];
            end
        end
    end

    assign bus.Data_bus_in = rd_data;

    always_comb begin
        cpu_wr      = ~bus.R_nW;
        ld_idx      = vec_idx(ld_addr);
        mem_we      = 1'b0;
        mem_idx     = bus.Addr_bus[MEM_AW-1:0];
        mem_wdata   = bus.Data_bus_out;
        vec_d       = vec_q;
        wr_cnt_d    = wr_cnt_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        wr_drop_d   = wr_drop_q;
        if (ld_we) begin
            // Preload owns the single write port; a coincident CPU write is lost.
            if (in_vec(ld_addr)) begin
                for (int i = 0; i < VEC_BYTES; i++) begin
                    if (ld_idx == 3'(i)) vec_d[i] = ld_data;
                end
            end else begin
                mem_we    = 1'b1;
                mem_idx   = ld_addr[MEM_AW-1:0];
                mem_wdata = ld_data;
            end
            if (cpu_wr) wr_drop_d = 1'b1;
        end else if (cpu_wr && !in_vec(bus.Addr_bus)) begin
            mem_we      = 1'b1;
            wr_cnt_d    = (&wr_cnt_q) ? wr_cnt_q : wr_cnt_q + 16'd1;
            last_addr_d = bus.Addr_bus;
            last_data_d = bus.Data_bus_out;
        end
    end

    always_ff @(posedge clk_ph1) begin
        if (mem_we) mem_q[mem_idx] <= mem_wdata;
    end

    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            wr_cnt_q    <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
            wr_drop_q   <= 1'b0;
            for (int i = 0; i < VEC_BYTES; i++) vec_q[i] <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
            wr_drop_q   <= wr_drop_d;
            vec_q       <= vec_d;
        end
    end

    irq_window_sched #(
        .NUM_WIN (NUM_WIN),
        .CNT_W   (CNT_W),
        .WIN_W   (WIN_W)
    ) u_sched (
        .clk       (clk_ph1),
        .rst_n     (rst),
        .cfg_we    (cfg_we),
        .cfg_win   (cfg_win),
        .cfg_fld   (cfg_fld),
        .cfg_data  (cfg_data),
        .cycle_cnt (cycle_cnt),
        .irq       (irq_w),
        .nmi       (nmi_w)
    );

    assign bus.irq      = irq_w;
    assign bus.nmi      = nmi_w;
    assign wr_cnt       = wr_cnt_q;
    assign last_wr_addr = last_addr_q;
    assign last_wr_data = last_data_q;
    assign wr_drop      = wr_drop_q;

endmodule

// File: tb/tb_cpu_bus_stim.sv
// Bench for cpu_bus_stim: directed scenarios plus randomized bus and window
// traffic, checked against a cycle-level behavioural model of the responder.
`timescale 1ns/1ps
module tb_cpu_bus_stim;
  import cpu_bus_pkg::*;

  localparam int MEM_N   = 2048;
  localparam int NUM_WIN = 4;

  logic        clk_ph1 = 1'b0;
  logic        rst     = 1'b1;
  logic        ld_we;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        cfg_we;
  logic [1:0]  cfg_win;
  logic [1:0]  cfg_fld;
  logic [15:0] cfg_data;
  logic [15:0] cycle_cnt;
  logic [15:0] wr_cnt;
  logic [15:0] last_wr_addr;
  logic [7:0]  last_wr_data;
  logic        wr_drop;

  cpu_bus_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  cpu_bus_stim #(
    .ADDR_W(16), .DATA_W(8), .MEM_AW(11), .NUM_WIN(NUM_WIN), .CNT_W(16)
  ) dut (
    .clk_ph1      (clk_ph1),
    .rst          (rst),
    .bus          (bus),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .cfg_we       (cfg_we),
    .cfg_win      (cfg_win),
    .cfg_fld      (cfg_fld),
    .cfg_data     (cfg_data),
    .cycle_cnt    (cycle_cnt),
    .wr_cnt       (wr_cnt),
    .last_wr_addr (last_wr_addr),
    .last_wr_data (last_wr_data),
    .wr_drop      (wr_drop)
  );

  // ---------------- clock ----------------
  always #5 clk_ph1 = ~clk_ph1;

  // ---------------- reference model ----------------
  logic [7:0]  ram_m [MEM_N];
  logic [7:0]  vec_m [6];
  logic [15:0] win_start [NUM_WIN];
  logic [15:0] win_end   [NUM_WIN];
  bit          win_en    [NUM_WIN];
  bit          win_kind  [NUM_WIN];
  logic [15:0] exp_cnt;
  logic [15:0] exp_wr_cnt;
  logic [15:0] exp_last_addr;
  logic [7:0]  exp_last_data;
  logic        exp_drop;
  logic        exp_irq;
  logic        exp_nmi;

  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] model_read(input logic [15:0] a);
    if (a >= 16'hFFFA) return vec_m[a - 16'hFFFA];
    return ram_m[a % MEM_N];
  endfunction

  // A line is asserted while the cycle count lies inside any enabled window of its kind.
  function automatic bit line_low(input bit kind, input logic [15:0] cnt);
    for (int w = 0; w < NUM_WIN; w++) begin
      if (win_en[w] && win_kind[w] == kind && win_start[w] <= cnt && cnt < win_end[w]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    exp_cnt       = 16'd0;
    exp_wr_cnt    = 16'd0;
    exp_last_addr = 16'd0;
    exp_last_data = 8'd0;
    exp_drop      = 1'b0;
    exp_irq       = 1'b1;
    exp_nmi       = 1'b1;
    for (int i = 0; i < 6; i++) vec_m[i] = 8'd0;
    for (int w = 0; w < NUM_WIN; w++) begin
      win_start[w] = 16'd0;
      win_end[w]   = 16'd0;
      win_en[w]    = 1'b0;
      win_kind[w]  = 1'b0;
    end
  endtask

  // One bus cycle: the edge applies the currently driven inputs to the model.
  task automatic step();
    @(posedge clk_ph1);
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    exp_irq = !line_low(1'b0, exp_cnt);
    exp_nmi = !line_low(1'b1, exp_cnt);
    if (cfg_we) begin
      case (cfg_fld)
        2'd0: win_start[cfg_win] = cfg_data;
        2'd1: win_end[cfg_win]   = cfg_data;
        2'd2: begin
          win_en[cfg_win]   = cfg_data[0];
          win_kind[cfg_win] = cfg_data[1];
        end
        default: ;
      endcase
    end
    if (ld_we) begin
      if (ld_addr >= 16'hFFFA) vec_m[ld_addr - 16'hFFFA] = ld_data;
      else ram_m[ld_addr % MEM_N] = ld_data;
      if (!bus.R_nW) exp_drop = 1'b1;
    end else if (!bus.R_nW && bus.Addr_bus < 16'hFFFA) begin
      ram_m[bus.Addr_bus % MEM_N] = bus.Data_bus_out;
      if (exp_wr_cnt != 16'hFFFF) exp_wr_cnt = exp_wr_cnt + 16'd1;
      exp_last_addr = bus.Addr_bus;
      exp_last_data = bus.Data_bus_out;
    end
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    ld_we            = 1'b0;
    cfg_we           = 1'b0;
    bus.R_nW         = 1'b1;
    bus.Data_bus_out = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (3) @(posedge clk_ph1);
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_we = 1'b0;
  endtask

  task automatic cfg_write(input int w, input int fld, input logic [15:0] d);
    cfg_we = 1'b1; cfg_win = 2'(w); cfg_fld = 2'(fld); cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic set_window(input int w, input logic [15:0] s, input logic [15:0] e, input bit kind);
    cfg_write(w, 0, s);
    cfg_write(w, 1, e);
    cfg_write(w, 2, {14'd0, kind, 1'b1});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst = 1'b0;
    idle();
    repeat (3) @(posedge clk_ph1);
    #1;
    checks++;
    if (bus.irq !== 1'b1 || bus.nmi !== 1'b1) begin
      failures++; $display("FAIL reset_lines: irq=%b nmi=%b expected 1/1", bus.irq, bus.nmi);
    end
    model_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (cycle_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_counts: cycle_cnt=%h wr_cnt=%h expected 0/0", cycle_cnt, wr_cnt);
    end
    checks++;
    if (last_wr_addr !== 16'h0000 || last_wr_data !== 8'h00 || wr_drop !== 1'b0) begin
      failures++; $display("FAIL reset_log: addr=%h data=%h drop=%b expected 0000/00/0", last_wr_addr, last_wr_data, wr_drop);
    end
    step();
    checks++;
    if (cycle_cnt !== 16'd1) begin
      failures++; $display("FAIL reset_first_edge: cycle_cnt=%h expected 0001", cycle_cnt);
    end
  endtask

  task automatic test_preload_read();
    for (int i = 0; i < MEM_N; i++) preload(16'(i), 8'($urandom_range(0, 255)));
    preload(16'h0000, 8'hA0);
    preload(16'h0001, 8'hFF);
    preload(16'hFFFE, 8'h00);
    preload(16'hFFFF, 8'h20);
    bus.Addr_bus = 16'h0001; #1;
    checks++;
    if (bus.Data_bus_in !== 8'hFF) begin
      failures++; $display("FAIL read_0001: got %h expected FF", bus.Data_bus_in);
    end
    bus.Addr_bus = 16'h0801; #1;
    checks++;
    if (bus.Data_bus_in !== 8'hFF) begin
      failures++; $display("FAIL read_mirror_0801: got %h expected FF", bus.Data_bus_in);
    end
    bus.Addr_bus = 16'hFFFF; #1;
    checks++;
    if (bus.Data_bus_in !== 8'h20) begin
      failures++; $display("FAIL read_vec_FFFF: got %h expected 20", bus.Data_bus_in);
    end
    bus.Addr_bus = 16'h0000; #1;
    checks++;
    if (bus.Data_bus_in !== 8'hA0) begin
      failures++; $display("FAIL read_0000: got %h expected A0", bus.Data_bus_in);
    end
    checks++;
    if (wr_cnt !== exp_wr_cnt) begin
      failures++; $display("FAIL preload_not_counted: wr_cnt=%h expected %h", wr_cnt, exp_wr_cnt);
    end
    step();
    for (int i = 0; i < 60; i++) begin
      bus.Addr_bus = 16'($urandom_range(0, 65535));
      bus.R_nW     = 1'($urandom_range(0, 1)) | 1'b1;
      #1;
      checks++;
      if (bus.Data_bus_in !== model_read(bus.Addr_bus)) begin
        failures++; $display("FAIL rand_read @%h: got %h expected %h", bus.Addr_bus, bus.Data_bus_in, model_read(bus.Addr_bus));
      end
      step();
    end
  endtask

  task automatic check_lines_until(input logic [15:0] last, input string tag);
    for (int i = 0; i < 200 && exp_cnt < last; i++) begin
      step();
      checks++;
      if (cycle_cnt !== exp_cnt || bus.irq !== exp_irq || bus.nmi !== exp_nmi) begin
        failures++;
        $display("FAIL %s @cnt %0d: cnt=%h irq=%b nmi=%b expected cnt=%h irq=%b nmi=%b",
                 tag, exp_cnt, cycle_cnt, bus.irq, bus.nmi, exp_cnt, exp_irq, exp_nmi);
      end
    end
  endtask

  task automatic test_irq_window();
    do_reset();
    set_window(0, 16'd5, 16'd20, 1'b0);
    check_lines_until(16'd25, "irq_window");
  endtask

  task automatic test_multi_window();
    do_reset();
    set_window(0, 16'd5, 16'd20, 1'b0);
    set_window(1, 16'd10, 16'd12, 1'b1);
    set_window(2, 16'd30, 16'd30, 1'b0);
    check_lines_until(16'd40, "multi_window");
  endtask

  task automatic test_cpu_write();
    do_reset();
    bus.Addr_bus = 16'h0102; bus.Data_bus_out = 8'h55; bus.R_nW = 1'b0;
    #1;
    checks++;
    if (bus.Data_bus_in !== model_read(16'h0102)) begin
      failures++; $display("FAIL read_during_write: got %h expected old %h", bus.Data_bus_in, model_read(16'h0102));
    end
    step();
    bus.R_nW = 1'b1;
    #1;
    checks++;
    if (bus.Data_bus_in !== 8'h55) begin
      failures++; $display("FAIL read_after_write: got %h expected 55", bus.Data_bus_in);
    end
    checks++;
    if (wr_cnt !== 16'd1 || last_wr_addr !== 16'h0102 || last_wr_data !== 8'h55) begin
      failures++; $display("FAIL write_log: cnt=%h addr=%h data=%h expected 0001/0102/55", wr_cnt, last_wr_addr, last_wr_data);
    end
    preload(16'hFFFE, 8'h00);
    bus.Addr_bus = 16'hFFFE; bus.Data_bus_out = 8'hAA; bus.R_nW = 1'b0;
    step();
    bus.R_nW = 1'b1;
    #1;
    checks++;
    if (bus.Data_bus_in !== 8'h00 || wr_cnt !== 16'd1 || last_wr_addr !== 16'h0102) begin
      failures++; $display("FAIL vec_write_ignored: data=%h cnt=%h addr=%h expected 00/0001/0102", bus.Data_bus_in, wr_cnt, last_wr_addr);
    end
    ld_we = 1'b1; ld_addr = 16'h0200; ld_data = 8'h3C;
    bus.Addr_bus = 16'h0300; bus.Data_bus_out = 8'hC3; bus.R_nW = 1'b0;
    step();
    idle();
    bus.Addr_bus = 16'h0200;
    #1;
    checks++;
    if (bus.Data_bus_in !== 8'h3C || wr_drop !== 1'b1 || wr_cnt !== 16'd1) begin
      failures++; $display("FAIL collision: data=%h drop=%b cnt=%h expected 3C/1/0001", bus.Data_bus_in, wr_drop, wr_cnt);
    end
    bus.Addr_bus = 16'h0300;
    #1;
    checks++;
    if (bus.Data_bus_in !== model_read(16'h0300)) begin
      failures++; $display("FAIL collision_cpu_lost: got %h expected %h", bus.Data_bus_in, model_read(16'h0300));
    end
    repeat (2) step();
    checks++;
    if (wr_drop !== 1'b1) begin
      failures++; $display("FAIL drop_sticky: got %b expected 1", wr_drop);
    end
  endtask

  task automatic test_random_rw();
    for (int i = 0; i < 300; i++) begin
      int op;
      op = $urandom_range(0, 3);
      idle();
      bus.Addr_bus = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFA, 16'hFFFF))
                                                 : 16'($urandom_range(0, 65535));
      bus.Data_bus_out = 8'($urandom_range(0, 255));
      if (op == 1 || op == 3) bus.R_nW = 1'b0;
      if (op >= 2) begin
        ld_we   = 1'b1;
        ld_addr = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(16'hFFFA, 16'hFFFF))
                                              : 16'($urandom_range(0, 65535));
        ld_data = 8'($urandom_range(0, 255));
      end
      #1;
      checks++;
      if (bus.Data_bus_in !== model_read(bus.Addr_bus)) begin
        failures++; $display("FAIL rw_read @%h: got %h expected %h", bus.Addr_bus, bus.Data_bus_in, model_read(bus.Addr_bus));
      end
      step();
      checks++;
      if (wr_cnt !== exp_wr_cnt || last_wr_addr !== exp_last_addr ||
          last_wr_data !== exp_last_data || wr_drop !== exp_drop) begin
        failures++;
        $display("FAIL rw_log op%0d: cnt=%h addr=%h data=%h drop=%b expected %h/%h/%h/%b", op,
                 wr_cnt, last_wr_addr, last_wr_data, wr_drop, exp_wr_cnt, exp_last_addr, exp_last_data, exp_drop);
      end
    end
    idle();
  endtask

  task automatic test_random_windows();
    do_reset();
    for (int i = 0; i < 150; i++) begin
      cfg_we = ($urandom_range(0, 2) == 0);
      cfg_win = 2'($urandom_range(0, 3));
      cfg_fld = 2'($urandom_range(0, 3));
      cfg_data = (cfg_fld == 2'd2) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 160));
      step();
      checks++;
      if (cycle_cnt !== exp_cnt || bus.irq !== exp_irq || bus.nmi !== exp_nmi) begin
        failures++;
        $display("FAIL rand_window @cnt %0d: cnt=%h irq=%b nmi=%b expected cnt=%h irq=%b nmi=%b",
                 exp_cnt, cycle_cnt, bus.irq, bus.nmi, exp_cnt, exp_irq, exp_nmi);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_window(0, 16'd5, 16'd20, 1'b0);
    for (int i = 0; i < 40 && exp_cnt != 16'd8; i++) step();
    checks++;
    if (bus.irq !== 1'b0 || cycle_cnt !== 16'd8) begin
      failures++; $display("FAIL pre_reset_irq: irq=%b cnt=%h expected 0/0008", bus.irq, cycle_cnt);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.irq !== 1'b1 || bus.nmi !== 1'b1 || cycle_cnt !== 16'd0) begin
      failures++; $display("FAIL async_release: irq=%b nmi=%b cnt=%h expected 1/1/0000", bus.irq, bus.nmi, cycle_cnt);
    end
    repeat (2) @(posedge clk_ph1);
    #1;
    model_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (cycle_cnt !== 16'd0) begin
      failures++; $display("FAIL restart_cnt: got %h expected 0000", cycle_cnt);
    end
    check_lines_until(16'd30, "post_reset");
  endtask

  // ---------------- main ----------------
  initial begin
    idle();
    bus.Addr_bus = 16'h0000;
    ld_addr = 16'h0000; ld_data = 8'h00;
    cfg_win = 2'd0; cfg_fld = 2'd0; cfg_data = 16'd0;
    model_reset();
    for (int i = 0; i < MEM_N; i++) ram_m[i] = 8'h00;
    test_reset();
    test_preload_read();
    test_irq_window();
    test_multi_window();
    test_cpu_write();
    test_random_rw();
    test_random_windows();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
